// File: rtl/bitwise_unit_arbiter_pkg.sv
// Shared types for the two-port bitwise unit arbiter.
// Opcode encodings and requester-id width.
package bitwise_pkg;

  localparam int OP_W = 2;
  localparam int ID_W = 1;

  typedef logic [OP_W-1:0] op_t;
  typedef logic [ID_W-1:0] req_id_t;

  localparam op_t OP_AND  = 2'd0;
  localparam op_t OP_NAND = 2'd1;
  localparam op_t OP_OR   = 2'd2;
  localparam op_t OP_NOR  = 2'd3;

endpackage

// File: rtl/bitwise_unit_arbiter_if.sv
// Request/response handshake bundle between the two front-ends,
// the arbiter and the writeback path.
interface bitwise_unit_arbiter_if #(
  parameter int nbits = 4
);
  import bitwise_pkg::*;

  logic             req0_val;
  logic             req0_rdy;
  op_t              req0_op;
  logic [nbits-1:0] req0_in0;
  logic [nbits-1:0] req0_in1;

  logic             req1_val;
  logic             req1_rdy;
  op_t              req1_op;
  logic [nbits-1:0] req1_in0;
  logic [nbits-1:0] req1_in1;

  logic             resp_val;
  logic             resp_rdy;
  req_id_t          resp_id;
  logic [nbits-1:0] resp_data;

  modport master (
    output req0_val, req0_op, req0_in0, req0_in1,
    output req1_val, req1_op, req1_in0, req1_in1,
    output resp_rdy,
    input  req0_rdy, req1_rdy,
    input  resp_val, resp_id, resp_data
  );

  modport slave (
    input  req0_val, req0_op, req0_in0, req0_in1,
    input  req1_val, req1_op, req1_in0, req1_in1,
    input  resp_rdy,
    output req0_rdy, req1_rdy,
    output resp_val, resp_id, resp_data
  );

endinterface

// File: rtl/bitwise_unit_arbiter_alu.sv
// Combinational AND/NAND/OR/NOR unit selected by opcode.
module bitwise_alu
  import bitwise_pkg::*;
#(
  parameter int nbits = 4
) (
  input  op_t              op,
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  output logic [nbits-1:0] out
);

  logic [nbits-1:0] f_and;
  logic [nbits-1:0] f_or;

  assign f_and = in0 & in1;
  assign f_or  = in0 | in1;

  always_comb begin
    out = f_and;
    unique case (op)
      OP_AND:  out = f_and;
      OP_NAND: out = ~f_and;
      OP_OR:   out = f_or;
      OP_NOR:  out = ~f_or;
      default: out = f_and;
    endcase
  end

endmodule

// File: rtl/bitwise_unit_arbiter.sv
// Round-robin share of one bitwise unit between two requesters,
// with a single registered response slot.
module bitwise_unit_arbiter
  import bitwise_pkg::*;
#(
  parameter int nbits = 4
) (
  input logic                  clk,
  input logic                  reset,
  bitwise_unit_arbiter_if.slave bus
);

  logic             prio;
  logic             rv;
  req_id_t          rid;
  logic [nbits-1:0] rd;

  logic             any_val;
  logic             can_acc;
  logic             fire;
  req_id_t          gnt;
  op_t              op;
  logic [nbits-1:0] a;
  logic [nbits-1:0] b;
  logic [nbits-1:0] alu_out;

  assign any_val = bus.req0_val | bus.req1_val;
  assign gnt = (bus.req0_val && bus.req1_val) ? prio : bus.req1_val;
  // slot frees up when empty or being drained this cycle
  assign can_acc = !rv || bus.resp_rdy;
  assign fire = can_acc && any_val;

  assign bus.req0_rdy = fire && (gnt == 1'b0);
  assign bus.req1_rdy = fire && (gnt == 1'b1);

  assign bus.resp_val  = rv;
  assign bus.resp_id   = rid;
  assign bus.resp_data = rd;

  always_comb begin
    op = bus.req0_op;
    a  = bus.req0_in0;
    b  = bus.req0_in1;
    if (gnt == 1'b1) begin
      op = bus.req1_op;
      a  = bus.req1_in0;
      b  = bus.req1_in1;
    end
  end

  bitwise_alu #(.nbits(nbits)) alu (
    .op  (op),
    .in0 (a),
    .in1 (b),
    .out (alu_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv   <= 1'b0;
      rid  <= '0;
      rd   <= '0;
      prio <= 1'b0;
    end else if (fire) begin
      rv   <= 1'b1;
      rid  <= gnt;
      rd   <= alu_out;
      prio <= ~gnt;
    end else if (bus.resp_rdy) begin
      rv   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed vector table plus reset and random sequences
// for the two-port bitwise unit arbiter.
module tb_bitwise_unit_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bitwise_unit_arbiter_if #(.nbits(4)) bus ();

  bitwise_unit_arbiter #(.nbits(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       v0;
    logic [1:0] op0;
    logic [3:0] a0, b0;
    logic       v1;
    logic [1:0] op1;
    logic [3:0] a1, b1;
    logic       rr;
    logic       e0, e1, erv, eid;
    logic [3:0] erd;
  } vec_t;

  vec_t tv[22];

  function automatic vec_t mk(
    logic v0, logic [1:0] op0, logic [3:0] a0, logic [3:0] b0,
    logic v1, logic [1:0] op1, logic [3:0] a1, logic [3:0] b1,
    logic rr, logic e0, logic e1, logic erv, logic eid,
    logic [3:0] erd);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rr = rr; v.e0 = e0; v.e1 = e1;
    v.erv = erv; v.eid = eid; v.erd = erd;
    return v;
  endfunction

  function automatic logic [3:0] ref_op(
    logic [1:0] op, logic [3:0] x, logic [3:0] y);
    case (op)
      2'd0:    return x & y;
      2'd1:    return ~(x & y);
      2'd2:    return x | y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic drive(
    logic v0, logic [1:0] op0, logic [3:0] a0, logic [3:0] b0,
    logic v1, logic [1:0] op1, logic [3:0] a1, logic [3:0] b1,
    logic rr);
    bus.req0_val = v0; bus.req0_op = op0;
    bus.req0_in0 = a0; bus.req0_in1 = b0;
    bus.req1_val = v1; bus.req1_op = op1;
    bus.req1_in0 = a1; bus.req1_in1 = b1;
    bus.resp_rdy = rr;
  endtask

  task automatic check(string nm, logic e0, logic e1,
                       logic erv, logic eid, logic [3:0] erd);
    logic [7:0] got, exp;
    got = {bus.req0_rdy, bus.req1_rdy, bus.resp_val,
           bus.resp_id, bus.resp_data};
    exp = {e0, e1, erv, eid, erd};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy0/rdy1/val/id/data=%b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
               nm, got[7], got[6], got[5], got[4], got[3:0],
               e0, e1, erv, eid, erd);
    end
  endtask

  logic       m_rv, m_id, m_prio;
  logic [3:0] m_d;

  initial begin
    // idle / single-port / opcode sweep
    tv[0]  = mk(0,0,0,0,       0,0,0,0,       1, 0,0,0,0,4'h0);
    tv[1]  = mk(1,0,4'hC,4'hA, 0,0,0,0,       1, 1,0,0,0,4'h0);
    tv[2]  = mk(0,0,0,0,       1,1,4'hC,4'hA, 1, 0,1,1,0,4'h8);
    tv[3]  = mk(0,0,0,0,       1,2,4'hC,4'hA, 1, 0,1,1,1,4'h7);
    tv[4]  = mk(0,0,0,0,       1,3,4'hC,4'hA, 1, 0,1,1,1,4'hE);
    tv[5]  = mk(0,0,0,0,       0,0,0,0,       1, 0,0,1,1,4'h1);
    tv[6]  = mk(0,0,0,0,       0,0,0,0,       1, 0,0,0,1,4'h1);
    // contention, alternating grants
    tv[7]  = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 1, 1,0,0,1,4'h1);
    tv[8]  = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 1, 0,1,1,0,4'h5);
    tv[9]  = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 1, 1,0,1,1,4'h3);
    tv[10] = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 1, 0,1,1,0,4'h5);
    // backpressure then drain-and-fire
    tv[11] = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 0, 0,0,1,1,4'h3);
    tv[12] = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 0, 0,0,1,1,4'h3);
    tv[13] = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 0, 0,0,1,1,4'h3);
    tv[14] = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 1, 1,0,1,1,4'h3);
    tv[15] = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 0, 0,0,1,0,4'h5);
    tv[16] = mk(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 1, 0,1,1,0,4'h5);
    // lone requester wins back-to-back against prio
    tv[17] = mk(1,0,4'hF,4'h5, 0,0,0,0,       1, 1,0,1,1,4'h3);
    tv[18] = mk(1,0,4'hF,4'h5, 0,0,0,0,       1, 1,0,1,0,4'h5);
    tv[19] = mk(0,0,0,0,       0,0,0,0,       0, 0,0,1,0,4'h5);
    tv[20] = mk(0,0,0,0,       0,0,0,0,       1, 0,0,1,0,4'h5);
    tv[21] = mk(0,0,0,0,       0,0,0,0,       1, 0,0,0,0,4'h5);

    drive(0,0,0,0, 0,0,0,0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      if (i != 0) @(negedge clk);
      drive(tv[i].v0, tv[i].op0, tv[i].a0, tv[i].b0,
            tv[i].v1, tv[i].op1, tv[i].a1, tv[i].b1, tv[i].rr);
      #1;
      check($sformatf("vec%0d", i), tv[i].e0, tv[i].e1,
            tv[i].erv, tv[i].eid, tv[i].erd);
    end

    // reset while a response is stalled; prio is 1 going in
    @(negedge clk);
    drive(1,0,4'hF,4'h5, 0,0,0,0, 0);
    #1 check("rst_load", 1,0,0,0,4'h5);
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0, 0);
    #1 check("rst_pend", 0,0,1,0,4'h5);
    #2 reset = 1'b1;
    #1 check("rst_async", 0,0,0,0,4'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1,0,4'hF,4'h5, 1,2,4'h0,4'h3, 1);
    #1 check("rst_prio0", 1,0,0,0,4'h0);
    @(negedge clk);
    #1 check("rst_next", 0,1,1,0,4'h5);

    // random traffic against a reference model
    @(negedge clk);
    reset = 1'b1;
    drive(0,0,0,0, 0,0,0,0, 1);
    @(negedge clk);
    reset = 1'b0;
    m_rv = 0; m_id = 0; m_d = 0; m_prio = 0;
    for (int c = 0; c < 1000; c++) begin
      logic v0, v1, rr, ca, g, f;
      logic [1:0] o0, o1;
      logic [3:0] a0, b0, a1, b1;
      if (c != 0) @(negedge clk);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      o0 = 2'($urandom); o1 = 2'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom);
      drive(v0,o0,a0,b0, v1,o1,a1,b1, rr);
      ca = !m_rv || rr;
      g  = (v0 && v1) ? m_prio : v1;
      f  = ca && (v0 || v1);
      #1 check($sformatf("rand%0d", c), f && !g, f && g,
               m_rv, m_id, m_d);
      if (f) begin
        m_rv = 1;
        m_id = g;
        m_d  = g ? ref_op(o1, a1, b1) : ref_op(o0, a0, b0);
        m_prio = ~g;
      end else if (rr) begin
        m_rv = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
